// File: rtl/regfile_pipe_m.sv
// Clocked architectural register file: two registered read ports with write bypass,
// an ALUSrc immediate mux on port B, and a busy scoreboard that stalls load-use reads.
module regfile_pipe_m #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  read1,
  input  logic [IDX_W-1:0]  read2,
  input  logic [DATA_W-1:0] immediate,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic [IDX_W-1:0]  writeRegister,
  input  logic [DATA_W-1:0] writeData,
  input  logic              mark_busy,
  input  logic [IDX_W-1:0]  mark_reg,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              rd_valid,
  output logic              stall
);

  // XZR has no storage; only indices below it are real registers.
  localparam int XZR = NREGS - 1;

  logic [DATA_W-1:0] reg_file_reg [XZR];
  logic [XZR-1:0]    busy_reg;

  logic [DATA_W-1:0] rd1_val, rd2_val;
  logic              hit1, hit2, busy1, busy2;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < XZR; gi++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          reg_file_reg[gi] <= '0;
        end else if (RegWrite && (writeRegister == IDX_W'(gi))) begin
          reg_file_reg[gi] <= writeData;
        end
      end

      // A newly issued load outranks a retiring write to the same register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          busy_reg[gi] <= 1'b0;
        end else if (mark_busy && (mark_reg == IDX_W'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (RegWrite && (writeRegister == IDX_W'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    rd1_val = '0;
    hit1    = 1'b0;
    busy1   = 1'b0;
    if (int'(read1) < XZR) begin
      hit1    = RegWrite && (writeRegister == read1);
      busy1   = busy_reg[read1];
      rd1_val = hit1 ? writeData : reg_file_reg[read1];
    end
  end

  always_comb begin
    rd2_val = '0;
    hit2    = 1'b0;
    busy2   = 1'b0;
    if (int'(read2) < XZR) begin
      hit2    = RegWrite && (writeRegister == read2);
      busy2   = busy_reg[read2];
      rd2_val = hit2 ? writeData : reg_file_reg[read2];
    end
  end

  // Same-cycle write to a busy register is forwarded, so it does not stall.
  assign stall  = rd_req & ((busy1 & ~hit1) | (~ALUSrc & busy2 & ~hit2));
  assign accept = rd_req & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data1    <= '0;
      data2    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        data1 <= rd1_val;
        data2 <= ALUSrc ? immediate : rd2_val;
      end
    end
  end

endmodule

// File: tb/tb_regfile_pipe_m.sv
// Scenario bench for regfile_pipe_m: expected read results are queued when a request
// is driven and matched by a monitor whenever rd_valid pulses.
module tb_regfile_pipe_m;

  localparam int DATA_W = 64;
  localparam int NREGS  = 32;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [IDX_W-1:0]  read1, read2;
  logic [DATA_W-1:0] immediate;
  logic              ALUSrc;
  logic              RegWrite;
  logic [IDX_W-1:0]  writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              mark_busy;
  logic [IDX_W-1:0]  mark_reg;
  logic [DATA_W-1:0] data1, data2;
  logic              rd_valid;
  logic              stall;

  int checks = 0;
  int errors = 0;
  logic [2*DATA_W-1:0] exp_q [$];

  regfile_pipe_m #(.DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .read1(read1), .read2(read2),
    .immediate(immediate), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .writeRegister(writeRegister), .writeData(writeData), .mark_busy(mark_busy),
    .mark_reg(mark_reg), .data1(data1), .data2(data2), .rd_valid(rd_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rd_req = 0; read1 = 5'd31; read2 = 5'd31; immediate = '0; ALUSrc = 0;
    RegWrite = 0; writeRegister = '0; writeData = '0; mark_busy = 0; mark_reg = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    exp_q.push_back({d1, d2});
  endtask

  task automatic monitor();
    logic [2*DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid: data1=%h data2=%h, required no result", data1, data2);
        end else begin
          e = exp_q.pop_front();
          if (data1 !== e[2*DATA_W-1:DATA_W] || data2 !== e[DATA_W-1:0]) begin
            errors++;
            $display("FAIL read_result: data1=%h data2=%h, required %h %h",
                     data1, data2, e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end else begin
            $display("read ok: data1=%h data2=%h", data1, data2);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_results: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data1 !== '0 || data2 !== '0 || rd_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: d1=%h d2=%h v=%b s=%b, required all 0", data1, data2, rd_valid, stall);
    end
    reset = 0;
    step();
    RegWrite = 1; writeRegister = 5'd1; writeData = 64'hAA;
    step();
    idle(); rd_req = 1; read1 = 5'd1; push(64'hAA, '0);
    step();
    idle();
    @(negedge clk); #1;
    reset = 1;
    #1;
    checks++;
    if (data1 !== '0 || data2 !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: d1=%h d2=%h v=%b, required 0 0 0", data1, data2, rd_valid);
    end
    @(posedge clk); #1;
    reset = 0;
    rd_req = 1; read1 = 5'd1; push('0, '0);
    step();
    idle();
    drain("reset");
  endtask

  task automatic test_write_read();
    RegWrite = 1; writeRegister = 5'd5; writeData = 64'h1234;
    step();
    idle(); rd_req = 1; read1 = 5'd5; read2 = 5'd5; push(64'h1234, 64'h1234);
    step();
    idle(); rd_req = 1; read1 = 5'd5;
    RegWrite = 1; writeRegister = 5'd5; writeData = 64'hBEEF; push(64'hBEEF, '0);
    step();
    idle(); rd_req = 1; read2 = 5'd5; push('0, 64'hBEEF);
    step();
    idle();
    drain("write_read");
  endtask

  task automatic test_xzr();
    RegWrite = 1; writeRegister = 5'd31; writeData = 64'hFFFF; mark_busy = 1; mark_reg = 5'd31;
    step();
    idle(); rd_req = 1; read1 = 5'd31; read2 = 5'd31;
    RegWrite = 1; writeRegister = 5'd31; writeData = 64'hFFFF; push('0, '0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL xzr_stall: stall=%b, required 0", stall);
    end
    step();
    idle();
    drain("xzr");
  endtask

  task automatic test_immediate();
    mark_busy = 1; mark_reg = 5'd7;
    step();
    idle(); rd_req = 1; read1 = 5'd5; read2 = 5'd7; ALUSrc = 1;
    immediate = 64'hFFFF_FFFF_FFFF_FF80; push(64'hBEEF, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL imm_stall: stall=%b, required 0", stall);
    end
    step();
    idle(); rd_req = 1; read2 = 5'd7;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reg2_busy_stall: stall=%b, required 1", stall);
    end
    step();
    RegWrite = 1; writeRegister = 5'd7; writeData = 64'd77; push('0, 64'd77);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reg2_bypass_stall: stall=%b, required 0", stall);
    end
    step();
    idle();
    drain("immediate");
  endtask

  task automatic test_load_use();
    logic [DATA_W-1:0] held;
    mark_busy = 1; mark_reg = 5'd3;
    step();
    idle(); rd_req = 1; read1 = 5'd3;
    held = data1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || rd_valid !== 1'b0 || data1 !== held) begin
        errors++;
        $display("FAIL load_use_stall%0d: stall=%b v=%b d1=%h, required 1 0 %h", i, stall, rd_valid, data1, held);
      end
      step();
    end
    RegWrite = 1; writeRegister = 5'd3; writeData = 64'd98; push(64'd98, '0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: stall=%b, required 0", stall);
    end
    step();
    idle();
    drain("load_use");
  endtask

  task automatic test_collision();
    mark_busy = 1; mark_reg = 5'd4; RegWrite = 1; writeRegister = 5'd4; writeData = 64'h44;
    step();
    idle(); rd_req = 1; read1 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL collision_stall%0d: stall=%b, required 1", i, stall);
      end
      step();
    end
    RegWrite = 1; writeRegister = 5'd4; writeData = 64'h55; push(64'h55, '0);
    step();
    idle();
    drain("collision");
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = {$urandom, $urandom};
      RegWrite = 1; writeRegister = IDX_W'(10 + i); writeData = vals[i];
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_req = 1; read1 = IDX_W'(10 + i); read2 = IDX_W'(17 - i);
      push(vals[i], vals[7 - i]);
      step();
    end
    idle();
    drain("back_to_back");
  endtask

  initial begin
    idle();
    reset = 1;
    fork
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_xzr();
    test_immediate();
    test_load_use();
    test_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
